// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core -- serial receive front end for the CPU's memory-mapped
// serial data/status registers.
//
// Synchronises the raw rxd pin and generates an oversampled baud tick. It
// deserialises 8N1 frames, LSB first, into a one-byte holding register with
// ready, overrun and framing-error status.
//
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames.
// This adds a PARITY state between DATA and STOP and the rx_parity_err output.
//
// Ports:
//   clk           system clock (CLK_FREQ Hz)
//   rst_n         asynchronous active-low reset
//   rxd           raw serial line, idle high, asynchronous to clk
//   rx_clear      one-cycle acknowledge from the CPU
//   rx_data       last accepted byte
//   rx_ready      holding register contains an unread byte
//   rx_overrun    a completed byte was dropped because rx_ready was set (sticky)
//   rx_frame_err  stop bit sampled low (sticky)
//   rx_busy       receiver FSM is outside IDLE
//   rx_parity_err even-parity mismatch (sticky, UART_RX_PARITY_EN only)
//   dbg_state     current FSM state encoding, for checkers and debug
//
// Handshake: rx_ready acts as "valid" for rx_data. The CPU reads rx_data
// while rx_ready=1 and then pulses rx_clear for one cycle as the
// acknowledge. rx_clear drops rx_ready, rx_overrun, rx_frame_err and
// rx_parity_err. A flag being set in the same cycle wins over the clear.
// A byte completing in that same cycle is written into rx_data and keeps
// rx_ready high.
module uart_rx_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic [2:0] dbg_state
);

  localparam int DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE) + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Synchroniser and edge detect
  logic       sync1, rxd_s, rxd_prev;
  logic [1:0] warm;
  logic       fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
      warm     <= 2'd0;
    end else begin
      sync1    <= rxd;
      rxd_s    <= sync1;
      rxd_prev <= rxd_s;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // The flops reset to 1, so the first real samples of a line held low
  // would look like a falling edge. Edges only count once rxd_prev holds a
  // genuine sample (three clocks after reset). A line held low at release
  // must therefore go high and fall again before it starts a frame.
  assign fall = (warm == 2'd3) && rxd_prev && !rxd_s;

  // Free-running baud tick
  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // Receiver FSM
  state_t        state, state_n;
  logic [TW-1:0] tick_cnt, tick_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          done_ok, done_ok_n;
  logic          done_bad, done_bad_n;
`ifdef UART_RX_PARITY_EN
  logic          par_bit, par_bit_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      done_ok  <= 1'b0;
      done_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      done_ok  <= done_ok_n;
      done_bad <= done_bad_n;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_bit_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    done_ok_n  = 1'b0;
    done_bad_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n  = par_bit;
`endif
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_n    = S_START;
          tick_cnt_n = '0;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a high line means a glitch
        if (tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_n = '0;
            if (rxd_s) begin
              state_n = S_IDLE;
            end else begin
              state_n   = S_DATA;
              bit_idx_n = '0;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_n = '0;
            // Shift in from the top: after eight bits, bit 0 holds the first one
            shift_n    = {rxd_s, shift[7:1]};
            bit_idx_n  = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_n = '0;
            par_bit_n  = rxd_s;
            state_n    = S_STOP;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        // Leave in the sample cycle so a start edge mid-stop-bit is caught
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_n = '0;
            state_n    = S_IDLE;
            done_ok_n  = rxd_s;
            done_bad_n = !rxd_s;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Holding register and status. The clear is applied first, so any set
  // below overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= 8'h00;
      rx_ready     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      if (rx_clear) begin
        rx_ready     <= 1'b0;
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        rx_parity_err <= 1'b0;
`endif
      end
      if (done_ok) begin
        // A clear in this cycle frees the register for the new byte
        if (!rx_ready || rx_clear) begin
          rx_data  <= shift;
          rx_ready <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
      if (done_bad) rx_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
      if ((done_ok || done_bad) && (^{shift, par_bit})) rx_parity_err <= 1'b1;
`endif
    end
  end

  assign rx_busy   = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int BIT = 432;  // clk per bit: 27 * 16
`ifdef UART_RX_PARITY_EN
  localparam int   EXP_LAT  = 4106 + BIT;
  localparam logic PAR_FLIP = 1'b1;
`else
  localparam int   EXP_LAT  = 4106;
  localparam logic PAR_FLIP = 1'b0;
`endif
  localparam int LAT_TOL = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, rx_overrun, rx_frame_err, rx_busy;
  logic [2:0] dbg_state;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  uart_rx_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .rx_clear     (rx_clear),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #10 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Drivers
  task automatic send_byte(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^data) ^ par_flip;
    repeat (BIT) @(negedge clk);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
  endtask

  function automatic logic [7:0] pop_exp();
    logic [7:0] v;
    v = 8'hxx;
    if (exp_q.size() > 0) v = exp_q.pop_front();
    return v;
  endfunction

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data); else n_pass++;
    n_checks++; if (rx_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", rx_ready); else n_pass++;
    n_checks++; if (rx_overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", rx_overrun); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", rx_busy); else n_pass++;
    n_checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
`ifdef UART_RX_PARITY_EN
    n_checks++; if (rx_parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b expected 0", rx_parity_err); else n_pass++;
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    exp_q.push_back(8'h55);
    fork
      send_byte(8'h55, 1'b1, 1'b0);
      begin
        lat = 0;
        @(negedge clk);
        while (rx_ready !== 1'b1 && lat < 6000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    n_checks++;
    if (lat < EXP_LAT - LAT_TOL || lat > EXP_LAT + LAT_TOL)
      $display("FAIL basic_latency: got %0d clk expected %0d +/- %0d", lat, EXP_LAT, LAT_TOL);
    else n_pass++;
    n_checks++; if (rx_ready !== 1'b1) $display("FAIL basic_ready: got %b expected 1", rx_ready); else n_pass++;
    begin
      logic [7:0] e;
      e = pop_exp();
      n_checks++; if (rx_data !== e) $display("FAIL basic_data: got %h expected %h", rx_data, e); else n_pass++;
    end
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", rx_busy); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL basic_frame_err: got %b expected 0", rx_frame_err); else n_pass++;
`ifdef UART_RX_PARITY_EN
    n_checks++; if (rx_parity_err !== 1'b0) $display("FAIL basic_parity_err: got %b expected 0", rx_parity_err); else n_pass++;
`endif
    pulse_clear();
    n_checks++; if (rx_ready !== 1'b0) $display("FAIL basic_clear_ready: got %b expected 0", rx_ready); else n_pass++;
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rxd = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy_during: got %b expected 1", rx_busy); else n_pass++;
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    repeat (500) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_after: got %b expected 0", rx_busy); else n_pass++;
    n_checks++; if (rx_ready !== 1'b0) $display("FAIL glitch_ready: got %b expected 0", rx_ready); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL glitch_frame_err: got %b expected 0", rx_frame_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    exp_q.push_back(8'hA5);  // 0x3C arrives while 0xA5 is unread and is dropped
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    e = pop_exp();
    n_checks++; if (rx_data !== e) $display("FAIL b2b_data: got %h expected %h", rx_data, e); else n_pass++;
    n_checks++; if (rx_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", rx_ready); else n_pass++;
    n_checks++; if (rx_overrun !== 1'b1) $display("FAIL b2b_overrun: got %b expected 1", rx_overrun); else n_pass++;
    pulse_clear();
    n_checks++;
    if ({rx_ready, rx_overrun, rx_frame_err} !== 3'b000)
      $display("FAIL b2b_clear: got %b expected 000", {rx_ready, rx_overrun, rx_frame_err});
    else n_pass++;
  endtask

  task automatic test_frame_err();
    apply_reset();
    send_byte(8'h81, 1'b0, 1'b0);
    repeat (BIT) @(negedge clk);
    n_checks++; if (rx_frame_err !== 1'b1) $display("FAIL ferr_flag: got %b expected 1", rx_frame_err); else n_pass++;
    n_checks++; if (rx_ready !== 1'b0) $display("FAIL ferr_ready: got %b expected 0", rx_ready); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL ferr_data: got %h expected 00", rx_data); else n_pass++;
    n_checks++; if (rx_overrun !== 1'b0) $display("FAIL ferr_overrun: got %b expected 0", rx_overrun); else n_pass++;
    pulse_clear();
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL ferr_clear: got %b expected 0", rx_frame_err); else n_pass++;
  endtask

  task automatic test_clear_same_cycle();
    logic [7:0] e;
    bit timed_out;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    e = pop_exp();
    n_checks++; if (rx_data !== e) $display("FAIL same_pre_data: got %h expected %h", rx_data, e); else n_pass++;
    n_checks++; if (rx_ready !== 1'b1) $display("FAIL same_pre_ready: got %b expected 1", rx_ready); else n_pass++;
    exp_q.push_back(8'h3C);
    timed_out = 1'b0;
    fork
      send_byte(8'h3C, 1'b1, 1'b0);
      begin
        int t;
        t = 0;
        while (rx_busy !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        while (rx_busy !== 1'b0 && t < 8000) begin @(negedge clk); t++; end
        // busy falls on the stop-sample edge; the byte lands on the next one
        if (t >= 8000 || rx_busy !== 1'b0) timed_out = 1'b1;
        else begin
          rx_clear = 1'b1;
          @(negedge clk);
          rx_clear = 1'b0;
        end
      end
    join
    n_checks++; if (timed_out !== 1'b0) $display("FAIL same_timeout: got %b expected 0", timed_out); else n_pass++;
    e = pop_exp();
    n_checks++; if (rx_data !== e) $display("FAIL same_data: got %h expected %h", rx_data, e); else n_pass++;
    n_checks++; if (rx_ready !== 1'b1) $display("FAIL same_ready: got %b expected 1", rx_ready); else n_pass++;
    n_checks++; if (rx_overrun !== 1'b0) $display("FAIL same_overrun: got %b expected 0", rx_overrun); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [7:0] e;
    bit busy_seen;
    d = 8'hF0;
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = d[4];
    repeat (200) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", rx_busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL mid_rst_data: got %h expected 00", rx_data); else n_pass++;
    n_checks++; if (rx_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b expected 0", rx_ready); else n_pass++;
    n_checks++; if (rx_overrun !== 1'b0) $display("FAIL mid_rst_overrun: got %b expected 0", rx_overrun); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL mid_rst_frame_err: got %b expected 0", rx_frame_err); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", rx_busy); else n_pass++;
    // Release with the line held low: no frame may start
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (rx_busy === 1'b1) busy_seen = 1'b1;
    end
    n_checks++; if (busy_seen !== 1'b0) $display("FAIL mid_low_line: got busy %b expected 0", busy_seen); else n_pass++;
    rxd = 1'b1;
    repeat (50) @(negedge clk);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, PAR_FLIP);
    repeat (10) @(negedge clk);
    e = pop_exp();
    n_checks++; if (rx_data !== e) $display("FAIL mid_after_data: got %h expected %h", rx_data, e); else n_pass++;
    n_checks++; if (rx_ready !== 1'b1) $display("FAIL mid_after_ready: got %b expected 1", rx_ready); else n_pass++;
`ifdef UART_RX_PARITY_EN
    n_checks++; if (rx_parity_err !== 1'b1) $display("FAIL mid_parity_err: got %b expected 1", rx_parity_err); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_frame_err();
    test_clear_same_cycle();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
